// File: rtl/note_seq_player.sv
// Melody sequencer: fetches note words from a synchronous song ROM and plays each as a square wave on spk.
// Optional NOTE_SEQ_ARTICULATION_GAP_EN inserts one silent step tick between consecutive notes.
module note_seq_player #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned BASE_OCT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_step,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [10:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              spk,
  output logic [5:0]        note_code,
  output logic              playing,
  output logic              done
);
  localparam int unsigned TONE_W = 19;
  localparam int unsigned DUR_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
`ifdef NOTE_SEQ_ARTICULATION_GAP_EN
    S_GAP,
`endif
    S_PLAY
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [5:0]          r_note_code, w_note_nxt;
  logic                r_last, w_last_nxt;
  logic [DUR_W-1:0]    r_dur_cnt, w_dur_nxt;
  logic [TONE_W-1:0]   r_tone_cnt, w_tone_nxt;
  logic                r_spk, w_spk_nxt;
  logic                r_done, w_done_nxt;
  logic                r_playing;
  logic [TONE_W-1:0]   w_half;
  logic                w_rest;

  // Half-period in clk cycles for {octave code, note}; octave 4 is the table reference.
  function automatic logic [TONE_W-1:0] half_period(input logic [5:0] code);
    logic [TONE_W-1:0] h4;
    int unsigned       oct;
    case (code[3:0])
      4'd1:    h4 = TONE_W'(191113);
      4'd2:    h4 = TONE_W'(180388);
      4'd3:    h4 = TONE_W'(170265);
      4'd4:    h4 = TONE_W'(160705);
      4'd5:    h4 = TONE_W'(151685);
      4'd6:    h4 = TONE_W'(143172);
      4'd7:    h4 = TONE_W'(135139);
      4'd8:    h4 = TONE_W'(127551);
      4'd9:    h4 = TONE_W'(120395);
      4'd10:   h4 = TONE_W'(113636);
      4'd11:   h4 = TONE_W'(107258);
      4'd12:   h4 = TONE_W'(101238);
      default: h4 = '0;
    endcase
    oct = BASE_OCT + 32'(code[5:4]);
    if (oct < 4) half_period = h4 << (4 - oct);
    else         half_period = h4 >> (oct - 4);
  endfunction

  assign w_half = half_period(r_note_code);
  assign w_rest = (r_note_code[3:0] == 4'd0) || (r_note_code[3:0] > 4'd12);

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_note_nxt  = r_note_code;
    w_last_nxt  = r_last;
    w_dur_nxt   = r_dur_cnt;
    w_tone_nxt  = '0;
    w_spk_nxt   = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_addr_nxt  = '0;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_note_nxt  = rom_data[5:0];
        w_last_nxt  = rom_data[10];
        w_dur_nxt   = (rom_data[9:6] == 4'd0) ? DUR_W'(1) : rom_data[9:6];
        w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        if (tick_step && (r_dur_cnt <= DUR_W'(1))) begin
          w_dur_nxt = '0;
          if (r_last && !loop_en) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_note_nxt  = '0;
          end else begin
            w_addr_nxt = r_last ? '0 : r_addr + ADDR_W'(1);
`ifdef NOTE_SEQ_ARTICULATION_GAP_EN
            w_state_nxt = S_GAP;
`else
            w_state_nxt = S_FETCH;
`endif
          end
        end else begin
          if (tick_step) w_dur_nxt = r_dur_cnt - DUR_W'(1);
          if (!w_rest) begin
            if (r_tone_cnt == w_half - TONE_W'(1)) begin
              w_spk_nxt  = ~r_spk;
              w_tone_nxt = '0;
            end else begin
              w_spk_nxt  = r_spk;
              w_tone_nxt = r_tone_cnt + TONE_W'(1);
            end
          end
        end
      end
`ifdef NOTE_SEQ_ARTICULATION_GAP_EN
      S_GAP: begin
        if (tick_step) w_state_nxt = S_FETCH;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort overrides everything, including a same-cycle start
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_addr_nxt  = '0;
      w_note_nxt  = '0;
      w_dur_nxt   = '0;
      w_tone_nxt  = '0;
      w_spk_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_note_code <= '0;
      r_last      <= 1'b0;
      r_dur_cnt   <= '0;
      r_tone_cnt  <= '0;
      r_spk       <= 1'b0;
      r_done      <= 1'b0;
      r_playing   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_note_code <= w_note_nxt;
      r_last      <= w_last_nxt;
      r_dur_cnt   <= w_dur_nxt;
      r_tone_cnt  <= w_tone_nxt;
      r_spk       <= w_spk_nxt;
      r_done      <= w_done_nxt;
      r_playing   <= (w_state_nxt != S_IDLE);
    end
  end

  assign rom_addr  = r_addr;
  assign spk       = r_spk;
  assign note_code = r_note_code;
  assign playing   = r_playing;
  assign done      = r_done;
endmodule

// File: tb/tb_note_seq_player.sv
// Directed self-checking bench for note_seq_player with a behavioural synchronous song ROM.
module tb_note_seq_player;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick_step, start, stop, loop_en;
  logic [10:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              spk, playing, done;
  logic [5:0]        note_code;
  logic [10:0]       rom [0:63];
  int                n_pass = 0;
  int                n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  note_seq_player #(.ADDR_W(ADDR_W), .BASE_OCT(3)) dut (
    .clk(clk), .rst_n(rst_n), .tick_step(tick_step), .start(start), .stop(stop),
    .loop_en(loop_en), .rom_data(rom_data), .rom_addr(rom_addr), .spk(spk),
    .note_code(note_code), .playing(playing), .done(done)
  );

  function automatic logic [10:0] mk_word(input logic last, input int unsigned dur,
                                          input int unsigned oct, input int unsigned note);
    return {last, 4'(dur), 2'(oct), 4'(note)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tick();
    tick_step = 1'b1;
    @(negedge clk);
    tick_step = 1'b0;
  endtask

  task automatic gap_tick();
`ifdef NOTE_SEQ_ARTICULATION_GAP_EN
    pulse_tick();
`endif
  endtask

  task automatic start_song();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_song();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = mk_word(1'b1, 1, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_total++; if (rom_addr !== 6'd0) $display("FAIL reset_addr: got %0d exp 0", rom_addr); else n_pass++;
    n_total++; if (spk !== 1'b0) $display("FAIL reset_spk: got %b exp 0", spk); else n_pass++;
    n_total++; if (note_code !== 6'h00) $display("FAIL reset_code: got %h exp 00", note_code); else n_pass++;
    n_total++; if (playing !== 1'b0) $display("FAIL reset_playing: got %b exp 0", playing); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b exp 0", done); else n_pass++;
    rst_n = 1'b1;
    cyc(3);
    n_total++; if (playing !== 1'b0) $display("FAIL reset_idle: got playing %b exp 0", playing); else n_pass++;
  endtask

  task automatic test_single_note();
    clear_rom();
    rom[0] = mk_word(1'b1, 2, 1, 10);
    loop_en = 1'b0;
    start_song();
    n_total++; if (rom_addr !== 6'd0) $display("FAIL single_fetch_addr: got %0d exp 0", rom_addr); else n_pass++;
    n_total++; if (playing !== 1'b1) $display("FAIL single_fetch_playing: got %b exp 1", playing); else n_pass++;
    cyc(2);
    n_total++; if (note_code !== 6'h1A) $display("FAIL single_code: got %h exp 1a", note_code); else n_pass++;
    cyc(1000);
    pulse_tick();
    n_total++; if (playing !== 1'b1 || done !== 1'b0)
      $display("FAIL single_tick1: got playing %b done %b exp 1 0", playing, done); else n_pass++;
    cyc(1000);
    pulse_tick();
    n_total++; if (done !== 1'b1) $display("FAIL single_done: got %b exp 1", done); else n_pass++;
    n_total++; if (playing !== 1'b0) $display("FAIL single_end_playing: got %b exp 0", playing); else n_pass++;
    n_total++; if (note_code !== 6'h00 || spk !== 1'b0)
      $display("FAIL single_end_out: got code %h spk %b exp 00 0", note_code, spk); else n_pass++;
    cyc(1);
    n_total++; if (done !== 1'b0) $display("FAIL single_done_width: got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_load_tick();
    clear_rom();
    rom[0] = mk_word(1'b0, 1, 2, 1);
    rom[1] = mk_word(1'b1, 1, 2, 3);
    loop_en = 1'b0;
    start_song();
    cyc(1);
    pulse_tick();
    n_total++; if (note_code !== 6'h21 || rom_addr !== 6'd0)
      $display("FAIL load_tick_ignored: got code %h addr %0d exp 21 0", note_code, rom_addr); else n_pass++;
    pulse_tick();
    n_total++; if (rom_addr !== 6'd1) $display("FAIL load_tick_next_addr: got %0d exp 1", rom_addr); else n_pass++;
`ifdef NOTE_SEQ_ARTICULATION_GAP_EN
    cyc(3);
    n_total++; if (note_code !== 6'h21 || playing !== 1'b1 || spk !== 1'b0)
      $display("FAIL gap_hold: got code %h playing %b spk %b exp 21 1 0", note_code, playing, spk); else n_pass++;
    pulse_tick();
`endif
    cyc(2);
    n_total++; if (note_code !== 6'h23) $display("FAIL load_tick_second: got %h exp 23", note_code); else n_pass++;
    pulse_tick();
    n_total++; if (done !== 1'b1 || playing !== 1'b0)
      $display("FAIL load_tick_end: got done %b playing %b exp 1 0", done, playing); else n_pass++;
  endtask

  task automatic test_loop_rest();
    int exp_addr [5] = '{0, 1, 2, 0, 1};
    logic [5:0] exp_code [5] = '{6'h11, 6'h10, 6'h15, 6'h11, 6'h10};
    int exp_dur [5] = '{1, 1, 3, 1, 1};
    clear_rom();
    rom[0] = mk_word(1'b0, 1, 1, 1);
    rom[1] = mk_word(1'b0, 1, 1, 0);
    rom[2] = mk_word(1'b1, 3, 1, 5);
    loop_en = 1'b1;
    start_song();
    cyc(2);
    for (int k = 0; k < 5; k++) begin
      n_total++; if (rom_addr !== 6'(exp_addr[k]) || note_code !== exp_code[k])
        $display("FAIL loop_step%0d: got addr %0d code %h exp %0d %h", k, rom_addr, note_code, exp_addr[k], exp_code[k]);
      else n_pass++;
      if (exp_code[k][3:0] == 4'd0) begin
        cyc(20);
        n_total++; if (spk !== 1'b0) $display("FAIL loop_rest_spk%0d: got %b exp 0", k, spk); else n_pass++;
      end
      for (int d = 1; d < exp_dur[k]; d++) pulse_tick();
      pulse_tick();
      n_total++; if (done !== 1'b0 || playing !== 1'b1)
        $display("FAIL loop_no_done%0d: got done %b playing %b exp 0 1", k, done, playing); else n_pass++;
      gap_tick();
      cyc(2);
    end
    stop_song();
    loop_en = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 64; i++) rom[i] = mk_word(1'b0, 1, 1, (i % 12) + 1);
    loop_en = 1'b0;
    start_song();
    cyc(2);
    for (int k = 0; k < 64; k++) begin
      if (k == 63) begin
        n_total++; if (rom_addr !== 6'd63 || note_code !== 6'h14)
          $display("FAIL wrap_last_addr: got addr %0d code %h exp 63 14", rom_addr, note_code); else n_pass++;
      end
      pulse_tick();
      gap_tick();
      cyc(2);
    end
    n_total++; if (rom_addr !== 6'd0 || note_code !== 6'h11 || playing !== 1'b1)
      $display("FAIL wrap_to_zero: got addr %0d code %h playing %b exp 0 11 1", rom_addr, note_code, playing);
    else n_pass++;
    stop_song();
  endtask

  task automatic test_stop_start();
    clear_rom();
    rom[0] = mk_word(1'b0, 1, 1, 1);
    rom[1] = mk_word(1'b1, 4, 1, 3);
    loop_en = 1'b0;
    start_song();
    cyc(2);
    pulse_tick();
    gap_tick();
    cyc(2);
    n_total++; if (rom_addr !== 6'd1 || note_code !== 6'h13)
      $display("FAIL stop_pre: got addr %0d code %h exp 1 13", rom_addr, note_code); else n_pass++;
    stop = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    start = 1'b0;
    n_total++; if (playing !== 1'b0 || rom_addr !== 6'd0)
      $display("FAIL stop_idle: got playing %b addr %0d exp 0 0", playing, rom_addr); else n_pass++;
    n_total++; if (note_code !== 6'h00 || spk !== 1'b0 || done !== 1'b0)
      $display("FAIL stop_outputs: got code %h spk %b done %b exp 00 0 0", note_code, spk, done); else n_pass++;
    cyc(3);
    n_total++; if (playing !== 1'b0 || done !== 1'b0)
      $display("FAIL stop_stays_idle: got playing %b done %b exp 0 0", playing, done); else n_pass++;
    start_song();
    cyc(2);
    n_total++; if (rom_addr !== 6'd0 || note_code !== 6'h11 || playing !== 1'b1)
      $display("FAIL stop_restart: got addr %0d code %h playing %b exp 0 11 1", rom_addr, note_code, playing);
    else n_pass++;
    stop_song();
  endtask

  task automatic test_tone();
    clear_rom();
    rom[0] = mk_word(1'b1, 15, 3, 10);
    start_song();
    cyc(2);
    n_total++; if (spk !== 1'b0) $display("FAIL tone_a_entry: got %b exp 0", spk); else n_pass++;
    cyc(28408);
    n_total++; if (spk !== 1'b0) $display("FAIL tone_a_before: got %b exp 0", spk); else n_pass++;
    cyc(1);
    n_total++; if (spk !== 1'b1) $display("FAIL tone_a_toggle: got %b exp 1", spk); else n_pass++;
    stop_song();
    n_total++; if (spk !== 1'b0) $display("FAIL tone_stop_spk: got %b exp 0", spk); else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    clear_rom();
    rom[0] = mk_word(1'b0, 1, 1, 1);
    rom[1] = mk_word(1'b1, 15, 3, 12);
    loop_en = 1'b0;
    start_song();
    cyc(2);
    pulse_tick();
    gap_tick();
    cyc(2);
    n_total++; if (rom_addr !== 6'd1 || note_code !== 6'h3C)
      $display("FAIL rst_pre_note: got addr %0d code %h exp 1 3c", rom_addr, note_code); else n_pass++;
    cyc(25308);
    n_total++; if (spk !== 1'b0) $display("FAIL tone_b_before: got %b exp 0", spk); else n_pass++;
    cyc(1);
    n_total++; if (spk !== 1'b1) $display("FAIL tone_b_toggle: got %b exp 1", spk); else n_pass++;
    #3 rst_n = 1'b0;
    #1;
    n_total++; if (spk !== 1'b0 || rom_addr !== 6'd0 || playing !== 1'b0 || note_code !== 6'h00)
      $display("FAIL rst_async: got spk %b addr %0d playing %b code %h exp 0 0 0 00", spk, rom_addr, playing, note_code);
    else n_pass++;
    cyc(3);
    #2 rst_n = 1'b1;
    cyc(5);
    n_total++; if (playing !== 1'b0 || rom_addr !== 6'd0)
      $display("FAIL rst_stays_idle: got playing %b addr %0d exp 0 0", playing, rom_addr); else n_pass++;
    start_song();
    n_total++; if (playing !== 1'b1 || rom_addr !== 6'd0)
      $display("FAIL rst_restart: got playing %b addr %0d exp 1 0", playing, rom_addr); else n_pass++;
    stop_song();
  endtask

  initial begin
    tick_step = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    clear_rom();
    test_reset();
    test_single_note();
    test_load_tick();
    test_loop_rest();
    test_wrap();
    test_stop_start();
    test_tone();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish exp finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
